// File: rtl/series_pkg.sv
// Shared constants, FSM encoding and series term sign/parity helpers for series_sched.
package series_pkg;

    localparam logic [1:0] FN_SIN = 2'd0;
    localparam logic [1:0] FN_COS = 2'd1;
    localparam logic [1:0] FN_LN  = 2'd2;
    localparam logic [1:0] FN_EXP = 2'd3;

    localparam int WDOG_LIMIT_DEF = 63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // sin keeps odd powers, cos even powers; ln and exp use every term
    function automatic logic term_add(input logic [1:0] fn, input logic [3:0] k);
        case (fn)
            FN_SIN:  return k[0];
            FN_COS:  return ~k[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic term_sub(input logic [1:0] fn, input logic [3:0] k);
        case (fn)
            FN_SIN:  return (k[1:0] == 2'd3);
            FN_COS:  return (k[1:0] == 2'd2);
            FN_LN:   return ~k[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin pick: search starts one past the previous winner.
module rr_arb4
    import series_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_gnt,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] cand_s;

    // Walk from lowest to highest priority so the nearest requester wins
    always_comb begin
        gnt    = 4'b0000;
        idx    = 2'd0;
        cand_s = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand_s = last_gnt + 2'(i);
            gnt    = req[cand_s] ? (4'b0001 << cand_s) : gnt;
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/series_sched.sv
// Series evaluation scheduler: arbitrates sin/cos/ln/exp requesters and sequences the term engine.
// Optional watchdog abort enabled by defining SERIES_SCHED_WDOG_EN.
module series_sched
    import series_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       eng_done,
    input  logic       eng_co,
    output logic       eng_start,
    output logic [3:0] gnt,
    output logic       acc_init,
    output logic       acc_init_one,
    output logic       acc_en,
    output logic       acc_sub,
    output logic [3:0] term_idx,
    output logic       busy,
    output logic [3:0] ack,
    output logic       err
);

    state_t     state_r, state_s;
    logic [3:0] req_r;
    logic [3:0] gnt_r;
    logic [1:0] gidx_r;
    logic [1:0] last_gnt_r;
    logic [3:0] term_idx_r;
    logic [3:0] arb_gnt_s;
    logic [1:0] arb_idx_s;
    logic       timeout_s;
    logic       err_src_s;

    rr_arb4 u_arb (
        .req      (req_r),
        .last_gnt (last_gnt_r),
        .gnt      (arb_gnt_s),
        .idx      (arb_idx_s)
    );

`ifdef SERIES_SCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_LIMIT + 1);
    logic [WDW-1:0] wdog_r;
    logic           err_r;

    // Watchdog: restarts on launch and on every term, otherwise counts WAIT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if ((state_r == ST_LAUNCH) || ((state_r == ST_WAIT) && eng_done)) begin
                wdog_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wdog_r <= wdog_r + WDW'(1);
            end else begin
                wdog_r <= wdog_r;
            end
            err_r <= timeout_s;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !eng_done && (wdog_r == WDW'(WDOG_LIMIT - 1));
    assign err_src_s = err_r;
`else
    assign timeout_s = 1'b0;
    assign err_src_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) state_s = ST_ARB;
                else      state_s = ST_IDLE;
            end
            ST_ARB:    state_s = ST_LAUNCH;
            ST_LAUNCH: state_s = ST_WAIT;
            ST_WAIT: begin
                if (eng_done && eng_co) state_s = ST_ACK;
                else if (timeout_s)     state_s = ST_ACK;
                else                    state_s = ST_WAIT;
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Transaction registers: request snapshot, grant, term index, fairness pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r      <= 4'b0000;
            gnt_r      <= 4'b0000;
            gidx_r     <= 2'd0;
            last_gnt_r <= 2'd3;
            term_idx_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: req_r <= req;
                ST_ARB: begin
                    gnt_r      <= arb_gnt_s;
                    gidx_r     <= arb_idx_s;
                    term_idx_r <= 4'd1;
                end
                ST_WAIT: begin
                    if (eng_done) term_idx_r <= term_idx_r + 4'd1;
                    else          term_idx_r <= term_idx_r;
                end
                ST_ACK: begin
                    last_gnt_r <= gidx_r;
                    gnt_r      <= 4'b0000;
                end
                default: req_r <= req_r;
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign term_idx = term_idx_r;

    // Output decode; accumulator controls follow eng_done combinationally in WAIT
    always_comb begin
        eng_start    = 1'b0;
        acc_init     = 1'b0;
        acc_init_one = 1'b0;
        acc_en       = 1'b0;
        acc_sub      = 1'b0;
        busy         = 1'b0;
        ack          = 4'b0000;
        err          = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_ARB: begin
                busy         = 1'b1;
                acc_init     = 1'b1;
                acc_init_one = (arb_idx_s == FN_COS) || (arb_idx_s == FN_EXP);
            end
            ST_LAUNCH: begin
                busy      = 1'b1;
                eng_start = 1'b1;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (eng_done) begin
                    acc_en  = term_add(gidx_r, term_idx_r);
                    acc_sub = term_sub(gidx_r, term_idx_r);
                end else begin
                    acc_en  = 1'b0;
                    acc_sub = 1'b0;
                end
            end
            ST_ACK: begin
                busy = 1'b1;
                ack  = gnt_r;
                err  = err_src_s;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_series_sched.sv
// Self-checking bench for series_sched against a Taylor-series / round-robin reference model.
// Watchdog expectations follow SERIES_SCHED_WDOG_EN.
module tb_series_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       eng_done;
    logic       eng_co;
    logic       eng_start;
    logic [3:0] gnt;
    logic       acc_init;
    logic       acc_init_one;
    logic       acc_en;
    logic       acc_sub;
    logic [3:0] term_idx;
    logic       busy;
    logic [3:0] ack;
    logic       err;

    int errors = 0;
    int checks = 0;
    int last_w;

    series_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .eng_done     (eng_done),
        .eng_co       (eng_co),
        .eng_start    (eng_start),
        .gnt          (gnt),
        .acc_init     (acc_init),
        .acc_init_one (acc_init_one),
        .acc_en       (acc_en),
        .acc_sub      (acc_sub),
        .term_idx     (term_idx),
        .busy         (busy),
        .ack          (ack),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester at or after last+1, cyclically
    function automatic int pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return 0;
    endfunction

    // Which Taylor terms x^k are present, using the 4-bit wrapped index
    function automatic bit model_en(input int fn, input int k);
        int kk = k % 16;
        case (fn)
            0:       return (kk % 2) == 1;
            1:       return (kk % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Sign of term k: sin (-1)^((k-1)/2), cos (-1)^(k/2), ln(1+x) (-1)^(k+1), exp +
    function automatic bit model_sub(input int fn, input int k);
        int kk = k % 16;
        case (fn)
            0:       return ((kk % 2) == 1) && ((((kk - 1) / 2) % 2) == 1);
            1:       return ((kk % 2) == 0) && (((kk / 2) % 2) == 1);
            2:       return (kk % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_w = 3;
    endtask

    task automatic run_txn(input logic [3:0] held, input int nterms, input bit jitter, output int w);
        logic [3:0] rem;
        req = held;
        w = pick(held, last_w);
        tick();
        chk("arb_busy", busy, 1);
        chk("arb_acc_init", acc_init, 1);
        chk("arb_init_one", acc_init_one, (w == 1 || w == 3) ? 1 : 0);
        tick();
        chk("launch_start", eng_start, 1);
        chk("launch_gnt", gnt, 32'd1 << w);
        chk("launch_idx", term_idx, 1);
        tick();
        chk("wait_start_once", eng_start, 0);
        for (int k = 1; k <= nterms; k++) begin
            if (jitter) begin
                repeat ($urandom_range(0, 2)) begin
                    eng_co = 1'($urandom);
                    req    = 4'($urandom);
                    #1;
                    chk("gap_acc_en", acc_en, 0);
                    tick();
                end
            end
            eng_done = 1'b1;
            eng_co   = (k == nterms);
            #1;
            chk("term_acc_en", acc_en, model_en(w, k));
            chk("term_acc_sub", acc_sub, model_sub(w, k));
            chk("term_idx", term_idx, k % 16);
            tick();
            eng_done = 1'b0;
            eng_co   = 1'b0;
        end
        rem = held & ~(4'b0001 << w);
        req = rem;
        chk("ack_onehot", ack, 32'd1 << w);
        chk("ack_err", err, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("ack_once", ack, 0);
        chk("gnt_cleared", gnt, 0);
        last_w = w;
    endtask

    initial begin
        int w;
        logic [3:0] held;
        rst = 1'b1;
        req = 4'b0000;
        eng_done = 1'b0;
        eng_co = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", term_idx, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_start", eng_start, 0);
        rst = 1'b0;
        last_w = 3;

        // sin with 5 terms, then cos with 4 terms
        run_txn(4'b0001, 5, 1'b0, w);
        run_txn(4'b0010, 4, 1'b0, w);

        // All four held: fairness from reset order, then 1001
        do_reset();
        held = 4'b1111;
        repeat (4) begin
            run_txn(held, 2, 1'b0, w);
            held = held & ~(4'b0001 << w);
        end
        run_txn(4'b1001, 1, 1'b0, w);
        run_txn(4'b1000, 1, 1'b0, w);

        // Stray engine pulse while idle
        eng_done = 1'b1;
        eng_co = 1'b1;
        #1;
        chk("idle_done_acc_en", acc_en, 0);
        tick();
        eng_done = 1'b0;
        eng_co = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ack", ack, 0);

        // Reset while waiting on term 3
        req = 4'b0100;
        tick();
        tick();
        tick();
        repeat (2) begin
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
        end
        chk("pre_rst_idx", term_idx, 3);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        last_w = 3;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_idx", term_idx, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_acc_init", acc_init, 0);
        tick();
        chk("mid_rst_no_ack", ack, 0);
        chk("mid_rst_idle", busy, 0);

        // Engine never reports a term after start
        req = 4'b0001;
        tick();
        tick();
        tick();
        req = 4'b0000;
`ifdef SERIES_SCHED_WDOG_EN
        for (int i = 1; i <= 63; i++) begin
            chk("wdog_waiting", ack, 0);
            if (i < 63) tick();
        end
        tick();
        chk("wdog_ack", ack, 4'b0001);
        chk("wdog_err", err, 1);
        tick();
        chk("wdog_idle", busy, 0);
        chk("wdog_err_clr", err, 0);
        last_w = 0;
`else
        repeat (100) tick();
        chk("nowdog_busy", busy, 1);
        chk("nowdog_ack", ack, 0);
        do_reset();
        chk("nowdog_rst_busy", busy, 0);
`endif

        // Randomized traffic with gaps, bus noise and term_idx wrap
        held = 4'b0000;
        for (int t = 0; t < 25; t++) begin
            if (held == 4'b0000) held = 4'($urandom_range(1, 15));
            run_txn(held, $urandom_range(1, 20), 1'b1, w);
            held = held & ~(4'b0001 << w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
